// File: rtl/rob_tag_ctrl_if.sv
// ============================================================================
// Module      : rob_tag_ctrl_if
// Description : Dispatch, CDB, status-table and commit bundle for rob_tag_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rob_tag_ctrl_if #(
  parameter int TAG_W = 6
);
  logic             disp_valid;
  logic             disp_ready;
  logic [4:0]       disp_rd;
  logic [TAG_W-1:0] disp_tag;
  logic             alloc_en;
  logic [4:0]       alloc_addr;
  logic [TAG_W-1:0] alloc_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic             rel_en;
  logic [4:0]       rel_addr;
  logic [TAG_W-1:0] rel_tag;
  logic             rel_force;
  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [TAG_W-1:0] commit_tag;
  logic             flush;
  logic             busy_flush;
  logic [31:0]      stat_commit_cnt;
  logic [31:0]      stat_full_cnt;

  modport master (
    output disp_valid, disp_rd, cdb_valid, cdb_tag, flush,
    input  disp_ready, disp_tag, alloc_en, alloc_addr, alloc_tag,
    input  rel_en, rel_addr, rel_tag, rel_force,
    input  commit_valid, commit_rd, commit_tag, busy_flush,
    input  stat_commit_cnt, stat_full_cnt
  );

  modport slave (
    input  disp_valid, disp_rd, cdb_valid, cdb_tag, flush,
    output disp_ready, disp_tag, alloc_en, alloc_addr, alloc_tag,
    output rel_en, rel_addr, rel_tag, rel_force,
    output commit_valid, commit_rd, commit_tag, busy_flush,
    output stat_commit_cnt, stat_full_cnt
  );
endinterface

`default_nettype wire

// File: rtl/rob_tag_ctrl.sv
// ============================================================================
// Module      : rob_tag_ctrl
// Description : ROB tag allocator with in-order commit and flush release walk.
//               Optional statistics counters enabled by ROB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_tag_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 6,
  parameter int NREG      = 32
) (
  input  wire logic    clk,
  input  wire logic    reset_n,
  rob_tag_ctrl_if.slave bus
);

  localparam int c_IDX_W  = $clog2(ROB_DEPTH);
  localparam int c_CNT_W  = c_IDX_W + 1;
  localparam int c_WALK_W = $clog2(NREG);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_head;
  logic [c_IDX_W-1:0]   r_tail;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_WALK_W-1:0]  r_walk;
  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [4:0]           r_rd [ROB_DEPTH];

  logic               w_disp_ready;
  logic               w_accept;
  logic               w_alloc_en;
  logic               w_commit;
  logic               w_rel_en;
  logic               w_rel_force;
  logic [4:0]         w_rel_addr;
  logic [TAG_W-1:0]   w_rel_tag;
  logic               w_busy;
  logic               w_cdb_hit;
  logic [c_IDX_W-1:0] w_cdb_idx;
  logic [4:0]         w_head_rd;
  logic [TAG_W-1:0]   w_head_tag;

  assign w_head_rd  = r_rd[r_head];
  assign w_head_tag = TAG_W'(r_head);
  assign w_cdb_idx  = bus.cdb_tag[c_IDX_W-1:0];
  // Tags beyond the ROB range never match an entry.
  assign w_cdb_hit  = bus.cdb_valid
                    & ({1'b0, bus.cdb_tag} < (TAG_W+1)'(ROB_DEPTH))
                    & r_valid[w_cdb_idx];

  always_comb begin
    w_state_nxt  = r_state;
    w_disp_ready = 1'b0;
    w_accept     = 1'b0;
    w_alloc_en   = 1'b0;
    w_commit     = 1'b0;
    w_rel_en     = 1'b0;
    w_rel_force  = 1'b0;
    w_rel_addr   = 5'd0;
    w_rel_tag    = '0;
    w_busy       = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_disp_ready = (r_count != c_CNT_W'(ROB_DEPTH));
        w_accept     = bus.disp_valid & w_disp_ready & ~bus.flush;
        w_alloc_en   = w_accept & (bus.disp_rd != 5'd0);
        w_commit     = r_valid[r_head] & r_done[r_head];
        // A same-cycle allocation of the register makes the new writer its owner.
        w_rel_en     = w_commit & (w_head_rd != 5'd0)
                     & ~(w_alloc_en & (bus.disp_rd == w_head_rd));
        if (w_rel_en) begin
          w_rel_addr = w_head_rd;
          w_rel_tag  = w_head_tag;
        end
      end
      ST_FLUSH: begin
        w_busy      = 1'b1;
        w_rel_en    = 1'b1;
        w_rel_force = 1'b1;
        w_rel_addr  = 5'(r_walk);
        if (r_walk == c_WALK_W'(NREG - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
    if (bus.flush) begin
      w_state_nxt = ST_FLUSH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_walk  <= '0;
      r_valid <= '0;
      r_done  <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rd[i] <= 5'd0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (bus.flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_valid <= '0;
        r_done  <= '0;
        r_walk  <= c_WALK_W'(1);
      end else if (r_state == ST_FLUSH) begin
        r_walk <= r_walk + c_WALK_W'(1);
      end else begin
        if (w_cdb_hit) begin
          r_done[w_cdb_idx] <= 1'b1;
        end
        if (w_commit) begin
          r_valid[r_head] <= 1'b0;
          r_done[r_head]  <= 1'b0;
          r_head          <= r_head + c_IDX_W'(1);
        end
        if (w_accept) begin
          r_valid[r_tail] <= 1'b1;
          r_done[r_tail]  <= 1'b0;
          r_rd[r_tail]    <= bus.disp_rd;
          r_tail          <= r_tail + c_IDX_W'(1);
        end
        if (w_accept && !w_commit) begin
          r_count <= r_count + c_CNT_W'(1);
        end else if (!w_accept && w_commit) begin
          r_count <= r_count - c_CNT_W'(1);
        end
      end
    end
  end

  assign bus.disp_ready   = w_disp_ready;
  assign bus.disp_tag     = TAG_W'(r_tail);
  assign bus.alloc_en     = w_alloc_en;
  assign bus.alloc_addr   = w_alloc_en ? bus.disp_rd : 5'd0;
  assign bus.alloc_tag    = w_alloc_en ? TAG_W'(r_tail) : '0;
  assign bus.commit_valid = w_commit;
  assign bus.commit_rd    = w_commit ? w_head_rd : 5'd0;
  assign bus.commit_tag   = w_commit ? w_head_tag : '0;
  assign bus.rel_en       = w_rel_en;
  assign bus.rel_addr     = w_rel_addr;
  assign bus.rel_tag      = w_rel_tag;
  assign bus.rel_force    = w_rel_force;
  assign bus.busy_flush   = w_busy;

`ifdef ROB_STATS_EN
  logic [31:0] r_stat_commit;
  logic [31:0] r_stat_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_commit <= 32'd0;
      r_stat_full   <= 32'd0;
    end else begin
      if (w_commit && !bus.flush && (r_stat_commit != 32'hFFFF_FFFF)) begin
        r_stat_commit <= r_stat_commit + 32'd1;
      end
      if ((r_state == ST_RUN) && bus.disp_valid && !w_disp_ready
          && (r_stat_full != 32'hFFFF_FFFF)) begin
        r_stat_full <= r_stat_full + 32'd1;
      end
    end
  end

  assign bus.stat_commit_cnt = r_stat_commit;
  assign bus.stat_full_cnt   = r_stat_full;
`else
  assign bus.stat_commit_cnt = 32'd0;
  assign bus.stat_full_cnt   = 32'd0;
`endif

endmodule

`default_nettype wire
